// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle fetch/decode/exec/wb sequencer for the core ALU.
// Define CTRL_PERF_EN to add the cyc_cnt/ret_cnt performance counters.
module alu_seq_ctrl #(
  parameter int PC_W     = 8,
  parameter int END_PC   = 255,
  parameter int WAIT_MAX = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [8:0]      instr,
  input  logic            alu_done,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc,
  output logic [4:0]      alu_op,
  output logic            alu_go,
  output logic [5:0]      imm,
  output logic            reg_we,
  output logic            busy,
  output logic            done,
  output logic [1:0]      err
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     ret_cnt
`endif
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_MAX);
  localparam logic [PC_W-1:0] END_V = PC_W'(END_PC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_DONE,
    S_FAULT
  } state_t;

  state_t          state;
  logic [8:0]      ir;
  logic            zf;
  logic [WC_W-1:0] wcnt;
  logic            is_bne;
  logic            is_bez;
  logic            take;
  logic [PC_W-1:0] off;
  logic [PC_W-1:0] npc;

  function automatic logic legal(input logic [4:0] op);
    case (op)
      5'b00100, 5'b00101, 5'b00110,
      5'b01101, 5'b01110: legal = 1'b0;
      default:            legal = 1'b1;
    endcase
  endfunction

  assign imm    = ir[5:0];
  assign is_bne = (ir[8:6] == 3'b101);
  assign is_bez = (ir[8:6] == 3'b110);
  assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                  (state == S_EXEC)  || (state == S_WB);
  assign done   = (state == S_DONE);

  always_comb begin
    take = 1'b0;
    unique case (1'b1)
      is_bne:  take = ~zf;
      is_bez:  take = zf;
      default: take = 1'b0;
    endcase
  end

  // branch offset is the 6-bit field sign-extended; pc wraps naturally
  always_comb begin
    off = take ? PC_W'($signed(imm)) : PC_W'(1);
    npc = pc + off;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      pc     <= '0;
      ir     <= '0;
      alu_op <= '0;
      alu_go <= 1'b0;
      reg_we <= 1'b0;
      err    <= 2'b00;
      zf     <= 1'b0;
      wcnt   <= '0;
    end else begin
      alu_go <= 1'b0;
      reg_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
          end
        end
        S_FETCH: begin
          ir    <= instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (!legal(ir[8:4])) begin
            state <= S_FAULT;
            err   <= 2'b01;
          end else begin
            state  <= S_EXEC;
            alu_op <= ir[8] ? {ir[8:6], 2'b00} : ir[8:4];
            alu_go <= 1'b1;
            wcnt   <= WC_W'(1);
          end
        end
        S_EXEC: begin
          if (alu_done) begin
            zf     <= alu_zero;
            reg_we <= ~(is_bne | is_bez);
            state  <= S_WB;
          end else if (wcnt == WC_MAX) begin
            state <= S_FAULT;
            err   <= 2'b10;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_WB: begin
          pc    <= npc;
          state <= (npc == END_V) ? S_DONE : S_FETCH;
        end
        S_FAULT: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CTRL_PERF_EN
  logic go_ok;
  assign go_ok = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk) begin
    if (reset || go_ok) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (busy && !(&cyc_cnt))
        cyc_cnt <= cyc_cnt + 1'b1;
      if ((state == S_WB) && !(&ret_cnt))
        ret_cnt <= ret_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench for alu_seq_ctrl with a latency-scripted
// ALU model; END_PC=1 so every program ends by landing on pc 1.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] instr;
  logic       alu_done;
  logic       alu_zero;
  logic [7:0] pc;
  logic [4:0] alu_op;
  logic       alu_go;
  logic [5:0] imm;
  logic       reg_we;
  logic       busy;
  logic       done;
  logic [1:0] err;
`ifdef CTRL_PERF_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ret_cnt;
`endif

  logic [8:0] rom [0:255];
  assign instr = rom[pc];

  alu_seq_ctrl #(
    .PC_W(8),
    .END_PC(1),
    .WAIT_MAX(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .instr(instr),
    .alu_done(alu_done),
    .alu_zero(alu_zero),
    .pc(pc),
    .alu_op(alu_op),
    .alu_go(alu_go),
    .imm(imm),
    .reg_we(reg_we),
    .busy(busy),
    .done(done),
    .err(err)
`ifdef CTRL_PERF_EN
    ,
    .cyc_cnt(cyc_cnt),
    .ret_cnt(ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic       we;
    logic [7:0] npc;
    int         ex;
    bit         nowb;
  } exp_t;

  typedef struct {
    int   lat;
    logic z;
  } alu_t;

  exp_t sb[$];
  alu_t aq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic push_i(input logic [4:0] op, input logic we,
                        input logic [7:0] npc, input int lat,
                        input logic z, input bit nowb);
    exp_t e;
    alu_t a;
    e.op   = op;
    e.we   = we;
    e.npc  = npc;
    e.ex   = lat + 1;
    e.nowb = nowb;
    a.lat  = lat;
    a.z    = z;
    sb.push_back(e);
    aq.push_back(a);
  endtask

  task automatic chk_rst(input string name);
    chk(name, {pc, alu_op, alu_go, imm, reg_we, busy, done, err}, 64'h0);
  endtask

  task automatic go_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n;
    n = 0;
    while (!done && n < maxc) begin
      tick();
      n++;
    end
    chk(name, done, 1);
  endtask

  // ALU model: latency counted in cycles after the go cycle, -1 = never
  initial begin
    int   cnt;
    logic z;
    alu_t a;
    alu_done = 1'b0;
    alu_zero = 1'b0;
    cnt = -1;
    z = 1'b0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (reset) begin
        cnt = -1;
      end else if (alu_go) begin
        if (aq.size() > 0) begin
          a = aq.pop_front();
          cnt = a.lat;
          z = a.z;
        end else begin
          cnt = -1;
        end
      end else if (cnt > 0) begin
        cnt--;
      end
      if (cnt == 0) begin
        alu_done = 1'b1;
        alu_zero = z;
        cnt = -1;
      end
    end
  end

  // monitor: every issue pops one expectation, then follows it to writeback
  initial begin
    exp_t e;
    int   n;
    forever begin
      @(posedge clk);
      #1;
      if (alu_go && !reset) begin
        chk("go_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("alu_op", alu_op, e.op);
          if (!e.nowb) begin
            n = 0;
            do begin
              @(posedge clk);
              #1;
              n++;
              if (n == 1)
                chk("go_one_cycle", alu_go, 0);
            end while (!alu_done && n < 64);
            chk("exec_cycles", n, e.ex);
            chk("alu_op_held", alu_op, e.op);
            chk("reg_we", reg_we, e.we);
            @(posedge clk);
            #1;
            chk("next_pc", pc, e.npc);
            chk("reg_we_pulse", reg_we, 0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = 9'h000;

    tick();
    tick();
    reset = 1'b0;
    chk_rst("reset_state");

    // single ADD at 0, ALU answers in the go cycle
    rom[0] = 9'h000;
    push_i(5'b00000, 1'b1, 8'd1, 0, 1'b0, 1'b0);
    go_start();
    chk("busy_fetch", busy, 1);
    tick();
    tick();
    tick();
    chk("done_c4", done, 0);
    tick();
    chk("done_c5", done, 1);
    chk("busy_done", busy, 0);
    chk("pc_done", pc, 1);

    // branch-heavy program, includes BEZ -2 taken/not taken and MOD stall
    rom[0] = 9'b101_000100;
    rom[4] = 9'b110_111110;
    rom[2] = 9'b01011_0011;
    rom[3] = 9'b101_000001;
    rom[5] = 9'b01100_0000;
    rom[6] = 9'b100_000101;
    rom[7] = 9'b111_101010;
    rom[8] = 9'b110_111001;
    push_i(5'b10100, 1'b0, 8'd4, 0, 1'b0, 1'b0);
    push_i(5'b11000, 1'b0, 8'd2, 0, 1'b1, 1'b0);
    push_i(5'b01011, 1'b1, 8'd3, 0, 1'b0, 1'b0);
    push_i(5'b10100, 1'b0, 8'd4, 1, 1'b0, 1'b0);
    push_i(5'b11000, 1'b0, 8'd5, 0, 1'b0, 1'b0);
    push_i(5'b01100, 1'b1, 8'd6, 5, 1'b0, 1'b0);
    push_i(5'b10000, 1'b1, 8'd7, 0, 1'b1, 1'b0);
    push_i(5'b11100, 1'b1, 8'd8, 2, 1'b0, 1'b0);
    push_i(5'b11000, 1'b0, 8'd1, 0, 1'b1, 1'b0);
    go_start();
    wait_done("prog_done", 300);
    chk("prog_pc", pc, 1);
    chk("prog_err", err, 0);
    chk("prog_sb_empty", sb.size(), 0);

    // illegal opcode 01101 faults in DECODE, start then ignored
    rom[0] = 9'b01101_0000;
    go_start();
    tick();
    tick();
    chk("illegal_err", err, 2'b01);
    chk("illegal_busy", busy, 0);
    go_start();
    tick();
    tick();
    chk("fault_hold_err", err, 2'b01);
    chk("fault_hold_busy", busy, 0);
    chk("fault_hold_done", done, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_rst("reset_after_illegal");

    // ALU never answers: timeout after 16 EXEC cycles
    rom[0] = 9'h000;
    push_i(5'b00000, 1'b0, 8'd0, -1, 1'b0, 1'b1);
    go_start();
    repeat (17) tick();
    chk("timeout_pre_err", err, 2'b00);
    chk("timeout_pre_busy", busy, 1);
    tick();
    chk("timeout_err", err, 2'b10);
    chk("timeout_busy", busy, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_rst("reset_after_timeout");

    // reset lands in the middle of a stalled MOD
    rom[0] = 9'b01100_0000;
    push_i(5'b01100, 1'b0, 8'd0, 5, 1'b0, 1'b1);
    go_start();
    repeat (4) tick();
    chk("mod_busy", busy, 1);
    chk("mod_op", alu_op, 5'b01100);
    reset = 1'b1;
    tick();
    chk_rst("reset_in_exec");
    reset = 1'b0;
    tick();
    tick();
    chk("idle_after_reset", busy, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
